uart_cmd_rx: RTL and testbench

- Receive-side counterpart of the button/switch instruction path. Takes bytes from the UART receiver (o_rx_data/o_rx_valid of uart_top) and parses ASCII-hex command lines of the form "HH<CR|LF>".
- Queues each parsed instruction word in a small FIFO.
- Issues queued instructions to the sequencer as single-cycle inst/inst_valid pulses, paced by the UART transmitter busy flag so that sequencer results are not lost.

---
 rtl/uart_cmd_rx_pkg.sv | 30 +++
 rtl/uart_cmd_rx_if.sv | 22 ++
 rtl/uart_cmd_rx_cmd_fifo.sv | 52 +++++
 rtl/uart_cmd_rx.sv | 132 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the UART command receiver: ASCII constants,
// parser state encoding and character-class helpers.
package uart_cmd_rx_pkg;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HI   = 2'd1,
    P_LO   = 2'd2,
    P_DISC = 2'd3
  } pstate_e;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic is_eol(input logic [7:0] c);
    return (c == CHR_CR) || (c == CHR_LF);
  endfunction

  // Letters 'A'/'a' both carry 1 in the low nibble, so add 9 to land on 0xA.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Byte-in / instruction-out bundle between the UART, the command
// receiver and the sequencer.
interface uart_cmd_rx_if #(parameter int IN_W = 8);
  logic [7:0]      i_rx_data;
  logic            i_rx_valid;
  logic            i_tx_busy;
  logic [IN_W-1:0] o_inst;
  logic            o_inst_valid;
  logic            o_frame_err;
  logic            o_ovf;
  logic [7:0]      o_inst_cnt;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_busy,
    output o_inst, o_inst_valid, o_frame_err, o_ovf, o_inst_cnt
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_busy,
    input  o_inst, o_inst_valid, o_frame_err, o_ovf, o_inst_cnt
  );
endinterface

// File: rtl/uart_cmd_rx_cmd_fifo.sv
// Small synchronous instruction FIFO. A push while full is accepted only
// when a pop happens in the same cycle; otherwise it is silently dropped.
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  always_comb begin
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d  = rd_en ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Parses "HH<CR|LF>" command lines from the UART, queues the words and
// issues them to the sequencer spaced out and held off while TX is busy.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 4
) (
  input logic            clk,
  input logic            rst_n,
  uart_cmd_rx_if.slave   bus
);
  localparam int GW = $clog2(ISSUE_GAP + 1);

  pstate_e         state_q, state_d;
  logic [3:0]      hi_q, hi_d, lo_q, lo_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            vld_q, vld_d;
  logic [IN_W-1:0] inst_q, inst_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            push, pop, full, empty;
  logic [IN_W-1:0] head;
  logic [7:0]      word;
  logic [7:0]      c;
  logic            c_hex, c_eol;

  assign c     = bus.i_rx_data;
  assign c_hex = is_hex(c);
  assign c_eol = is_eol(c);
  assign word  = {hi_q, lo_q};

  cmd_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word[IN_W-1:0]),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (bus.i_rx_valid) begin
      unique case (state_q)
        P_IDLE: begin
          if (c_hex) begin
            hi_d    = hex_nib(c);
            state_d = P_HI;
          end else if (!c_eol) begin
            err_d   = 1'b1;
            state_d = P_DISC;
          end
        end
        P_HI: begin
          if (c_hex) begin
            lo_d    = hex_nib(c);
            state_d = P_LO;
          end else begin
            err_d   = 1'b1;
            state_d = c_eol ? P_IDLE : P_DISC;
          end
        end
        P_LO: begin
          if (c_eol) begin
            push    = 1'b1;
            state_d = P_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = P_DISC;
          end
        end
        P_DISC: begin
          if (c_eol) state_d = P_IDLE;
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  // The !vld_q term guarantees a one-cycle strobe even if ISSUE_GAP were 0.
  always_comb begin
    pop    = !empty && !bus.i_tx_busy && (gap_q == '0) && !vld_q;
    vld_d  = pop;
    inst_d = pop ? head : inst_q;
    cnt_d  = cnt_q + 8'(pop);
    if (pop)                gap_d = GW'(ISSUE_GAP);
    else if (gap_q != '0)   gap_d = gap_q - GW'(1);
    else                    gap_d = gap_q;
    ovf_d  = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = vld_q;
  assign bus.o_frame_err  = err_q;
  assign bus.o_ovf        = ovf_q;
  assign bus.o_inst_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: parsing, pacing, overflow, async reset
// and counter wrap, with hand-computed expectations.
module tb_uart_cmd_rx;
  localparam int IN_W = 8, DEPTH = 4, GAP = 4;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_rx_if #(.IN_W(IN_W)) bus();

  uart_cmd_rx #(.IN_W(IN_W), .DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Monitor: log every issued word with its cycle stamp, count error pulses.
  int cyc = 0, err_tot = 0;
  logic [7:0] iss_v[$];
  int         iss_c[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.o_inst_valid === 1'b1) begin
      iss_v.push_back(bus.o_inst);
      iss_c.push_back(cyc);
    end
    if (bus.o_frame_err === 1'b1) err_tot++;
  end

  function automatic logic [7:0] get_v(input int i);
    return (i < iss_v.size()) ? iss_v[i] : 8'hxx;
  endfunction

  function automatic int get_c(input int i);
    return (i < iss_c.size()) ? iss_c[i] : -1000;
  endfunction

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=%0d want=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int b, e0;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_busy  = 1'b0;
    idle(3);
    chk("rst_inst", bus.o_inst, 0);
    chk("rst_vld",  bus.o_inst_valid, 0);
    chk("rst_err",  bus.o_frame_err, 0);
    chk("rst_ovf",  bus.o_ovf, 0);
    chk("rst_cnt",  bus.o_inst_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    // Single line, minimum latency
    e0 = err_tot;
    send_str("3C");
    send_byte(CR);
    chk("t1_lat0", bus.o_inst_valid, 0);
    idle(1);
    chk("t1_vld",  bus.o_inst_valid, 1);
    chk("t1_inst", bus.o_inst, 8'h3C);
    chk("t1_cnt",  bus.o_inst_cnt, 1);
    idle(1);
    chk("t1_pulse", bus.o_inst_valid, 0);
    chk("t1_hold",  bus.o_inst, 8'h3C);
    idle(6);
    chk("t1_noerr", err_tot - e0, 0);

    // Held by busy, then spaced by ISSUE_GAP+1
    b = iss_v.size();
    bus.i_tx_busy = 1'b1;
    send_str("a5");
    send_byte(LF);
    send_str("12");
    send_byte(CR);
    idle(44);
    chk("t2_held", iss_v.size() - b, 0);
    bus.i_tx_busy = 1'b0;
    idle(20);
    chk("t2_n",   iss_v.size() - b, 2);
    chk("t2_v0",  get_v(b), 8'hA5);
    chk("t2_v1",  get_v(b + 1), 8'h12);
    chk("t2_gap", get_c(b + 1) - get_c(b), GAP + 1);
    chk("t2_cnt", bus.o_inst_cnt, 3);

    // Malformed lines
    e0 = err_tot;
    b  = iss_v.size();
    send_str("G1");
    send_byte(CR);
    send_str("7");
    send_byte(CR);
    chk("t3_errpulse", bus.o_frame_err, 1);
    send_str("123");
    send_byte(CR);
    chk("t3_noissue", iss_v.size() - b, 0);
    send_str("0F");
    send_byte(CR);
    idle(10);
    chk("t3_errs", err_tot - e0, 3);
    chk("t3_n",    iss_v.size() - b, 1);
    chk("t3_v",    get_v(b), 8'h0F);
    chk("t3_cnt",  bus.o_inst_cnt, 4);

    // Overflow while busy
    b = iss_v.size();
    bus.i_tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'h30);
      send_byte(hexc(i));
      send_byte(CR);
      if (i == 4) chk("t4_ovf4", bus.o_ovf, 0);
    end
    chk("t4_ovf5", bus.o_ovf, 1);
    bus.i_tx_busy = 1'b0;
    idle(40);
    chk("t4_n", iss_v.size() - b, 4);
    for (int i = 0; i < 4; i++) chk("t4_v", get_v(b + i), 8'(i + 1));
    chk("t4_cnt",    bus.o_inst_cnt, 8);
    chk("t4_sticky", bus.o_ovf, 1);

    // Asynchronous reset mid-line with words queued
    bus.i_tx_busy = 1'b1;
    send_str("11");
    send_byte(CR);
    send_str("22");
    send_byte(CR);
    send_str("4");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_inst", bus.o_inst, 0);
    chk("t5_cnt",  bus.o_inst_cnt, 0);
    chk("t5_ovf",  bus.o_ovf, 0);
    chk("t5_vld",  bus.o_inst_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_tx_busy = 1'b0;
    idle(1);
    b = iss_v.size();
    send_str("5A");
    send_byte(CR);
    idle(20);
    chk("t5_n",    iss_v.size() - b, 1);
    chk("t5_v",    get_v(b), 8'h5A);
    chk("t5_cnt1", bus.o_inst_cnt, 1);

    // Blank lines
    e0 = err_tot;
    b  = iss_v.size();
    send_byte(CR);
    send_byte(LF);
    send_byte(CR);
    send_byte(LF);
    idle(10);
    chk("t6_err", err_tot - e0, 0);
    chk("t6_n",   iss_v.size() - b, 0);

    // Counter wrap over 256 issues
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 256; i++) begin
      send_byte(hexc(i >> 4));
      send_byte(hexc(i & 15));
      send_byte(CR);
      idle(4);
      if (i == 254) chk("t7_cnt255", bus.o_inst_cnt, 255);
    end
    idle(10);
    chk("t7_wrap", bus.o_inst_cnt, 0);
    chk("t7_last", get_v(iss_v.size() - 1), 8'hFF);
    chk("t7_ovf",  bus.o_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
